// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard controller for the 5-stage pipeline.
// It keeps a shadow copy of the X/M/W destination tags, generates the X-stage
// operand bypass selects, detects load-use hazards and freezes the pipeline
// while a multi-cycle mult/div operation is busy.
module hazard_forward_unit #(
    parameter int REG_W      = 5,
    parameter int MD_LATENCY = 32,
    parameter int MD_CNT_W   = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs_a,
    input  logic [REG_W-1:0] dec_rs_b,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_we,
    input  logic             dec_load,
    input  logic             dec_md,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall_d,
    output logic             md_stall
);

    // The X entry needs sources (for bypass compares) and the load flag
    // (for load-use detection).
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs_a;
        logic [REG_W-1:0] rs_b;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             load;
    } x_entry_t;

    // M and W only act as producers, so only their destination side is kept.
    // A load in M is never a bypass source because the load-use stall keeps
    // its consumer out of X until the load has reached W.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
    } wb_entry_t;

    localparam logic [REG_W-1:0]    ZERO_REG = '0;
    localparam logic [MD_CNT_W-1:0] MD_LOAD  = MD_CNT_W'(MD_LATENCY);
    localparam logic [MD_CNT_W-1:0] MD_ONE   = MD_CNT_W'(1);

    x_entry_t            x_stage;
    wb_entry_t           m_stage;
    wb_entry_t           w_stage;
    logic [MD_CNT_W-1:0] md_count;

    logic m_writer;
    logic w_writer;
    logic x_load_writer;
    logic issue_md;

    // Register 0 is hardwired, so a stage writing it is never a producer.
    assign m_writer      = m_stage.valid & m_stage.we & (m_stage.rd != ZERO_REG);
    assign w_writer      = w_stage.valid & w_stage.we & (w_stage.rd != ZERO_REG);
    assign x_load_writer = x_stage.valid & x_stage.load & x_stage.we
                           & (x_stage.rd != ZERO_REG);

    assign md_stall = (md_count != '0);

    // A mult/div only starts when it actually enters X this cycle.
    assign issue_md = dec_valid & dec_md & ~stall_d & ~flush & ~md_stall;

    // Load-use detection between the decode instruction and a load sitting in X.
    always_comb begin
        stall_d = 1'b0;
        if (dec_valid && x_load_writer &&
            ((x_stage.rd == dec_rs_a) || (x_stage.rd == dec_rs_b))) begin
            stall_d = 1'b1;
        end
    end

    // Operand bypass selects; M wins over W because it holds the newer value.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (x_stage.valid) begin
            if (m_writer && (m_stage.rd == x_stage.rs_a)) begin
                fwd_a_sel = 2'b01;
            end else if (w_writer && (w_stage.rd == x_stage.rs_a)) begin
                fwd_a_sel = 2'b10;
            end
            if (m_writer && (m_stage.rd == x_stage.rs_b)) begin
                fwd_b_sel = 2'b01;
            end else if (w_writer && (w_stage.rd == x_stage.rs_b)) begin
                fwd_b_sel = 2'b10;
            end
        end
    end

    // Mult/div busy counter: loaded on issue, counts down while frozen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_count <= '0;
        end else if (md_stall) begin
            md_count <= md_count - MD_ONE;
        end else if (issue_md) begin
            md_count <= MD_LOAD;
        end
    end

    // Shadow pipeline advance; frozen while mult/div is busy, bubble on stall or flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_stage <= '0;
            m_stage <= '0;
            w_stage <= '0;
        end else if (!md_stall) begin
            w_stage <= m_stage;
            m_stage.valid <= x_stage.valid;
            m_stage.rd    <= x_stage.rd;
            m_stage.we    <= x_stage.we;
            if (stall_d || flush) begin
                x_stage <= '0;
            end else begin
                x_stage.valid <= dec_valid;
                x_stage.rs_a  <= dec_rs_a;
                x_stage.rs_b  <= dec_rs_b;
                x_stage.rd    <= dec_rd;
                x_stage.we    <= dec_we;
                x_stage.load  <= dec_load;
            end
        end
    end

endmodule
